soft_spi_slave_burst: RTL and testbench

Parametrised SPI register-port slave: next generation of the MCU-facing SPI slave, supporting all four SPI modes and configurable address/data widths. It adds burst transfers with address auto-increment, a read request/valid handshake with next-word prefetch, and abort detection. It sits between the MCU SPI pins and the DSP register file, fully synchronous to the FPGA system clock, with the SPI lines oversampled.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 24 ++
 rtl/soft_spi_slave_burst.sv | 241 ++++++++++++++++++++++++
 tb/tb_soft_spi_slave_burst.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: mode encodings, FSM states and frame-length helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  // Total SCK samples in a frame carrying nwords data words.
  function automatic int spi_frame_bits(input int aw, input int dw, input int nwords);
    return 1 + aw + nwords * dw;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop for edge pulses.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {3{RST_VAL}};
    else         sync_q <= {sync_q[1:0], pin_i};
  end

  assign lvl_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/soft_spi_slave_burst.sv
// Oversampled SPI register-port slave with burst transfers, read prefetch and abort detection.
module soft_spi_slave_burst
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ncs,
  input  logic                  si,
  output logic                  so,
  output logic                  so_oe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_stb,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  busy,
  output logic                  rd_miss,
  output logic                  abort
);

  localparam int HDR_BITS = 1 + ADDR_WIDTH;
  localparam int CNT_MAX  = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HDR_LAST  = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [1:0] MODE = {1'(CPOL), 1'(CPHA)};
  // SCK level right after a sample edge (rising edge samples in modes 0 and 3).
  localparam logic SAMP_LVL = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

  logic sck_lvl, sck_r, sck_f, ncs_lvl, ncs_r, ncs_f;
  logic [1:0] si_q;
  logic si_s, sck_edge, samp, launch;

  // ncs resets low so a frame already running at reset release never shows a fall.
  spi_pin_sync #(.RST_VAL(1'(CPOL))) u_sck_sync (
    .clk_i(clk), .rst_ni(rst), .pin_i(sck), .lvl_o(sck_lvl), .rise_o(sck_r), .fall_o(sck_f)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_ncs_sync (
    .clk_i(clk), .rst_ni(rst), .pin_i(ncs), .lvl_o(ncs_lvl), .rise_o(ncs_r), .fall_o(ncs_f)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) si_q <= '0;
    else      si_q <= {si_q[0], si};
  end

  assign si_s     = si_q[1];
  assign sck_edge = sck_r | sck_f;
  assign samp     = sck_edge & (sck_lvl == SAMP_LVL);
  assign launch   = sck_edge & (sck_lvl != SAMP_LVL);

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] hdr_q, hdr_d, addr_q, addr_d, req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, hold_q, hold_d, wr_data_q, wr_data_d;
  logic                  rw_q, rw_d, held_q, held_d, pend_q, pend_d, ldpend_q, ldpend_d;
  logic                  wr_stb_q, wr_stb_d, rd_req_q, rd_req_d;
  logic                  rd_miss_q, rd_miss_d, abort_q, abort_d, arm_q;
  logic [HDR_BITS-1:0]   hdr_in;
  logic [DATA_WIDTH-1:0] word_in;

  assign hdr_in  = {hdr_q, si_s};
  assign word_in = {rx_q[DATA_WIDTH-2:0], si_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    req_addr_d = req_addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    held_d     = held_q;
    pend_d     = pend_q;
    ldpend_d   = ldpend_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    wr_stb_d   = 1'b0;
    rd_req_d   = 1'b0;
    rd_miss_d  = 1'b0;
    abort_d    = 1'b0;

    if (ncs_r) begin
      // Deselect wins over any SCK edge seen in the same cycle.
      state_d  = IDLE;
      cnt_d    = '0;
      tx_d     = '0;
      pend_d   = 1'b0;
      held_d   = 1'b0;
      ldpend_d = 1'b0;
      abort_d  = (state_q == HDR) || ((state_q == DATA) && (cnt_q != '0));
    end else begin
      if (pend_q && rd_valid) begin
        hold_d = rd_data;
        held_d = 1'b1;
        pend_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (ncs_f) begin
            state_d  = HDR;
            cnt_d    = '0;
            tx_d     = '0;
            held_d   = 1'b0;
            pend_d   = 1'b0;
            ldpend_d = 1'b0;
          end
        end
        HDR: begin
          if (samp) begin
            hdr_d = hdr_in[HDR_BITS-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HDR_LAST) begin
              state_d = DATA;
              cnt_d   = '0;
              rw_d    = hdr_in[ADDR_WIDTH];
              addr_d  = hdr_in[ADDR_WIDTH-1:0];
              if (hdr_in[ADDR_WIDTH]) begin
                rd_addr_d  = hdr_in[ADDR_WIDTH-1:0];
                req_addr_d = hdr_in[ADDR_WIDTH-1:0];
                rd_req_d   = 1'b1;
                pend_d     = 1'b1;
                held_d     = 1'b0;
                ldpend_d   = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (samp) begin
            rx_d  = word_in;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d = '0;
              if (rw_q) begin
                ldpend_d = 1'b1;
              end else begin
                wr_addr_d = addr_q;
                wr_data_d = word_in;
                wr_stb_d  = 1'b1;
                addr_d    = addr_q + ADDR_STEP;
              end
            end
          end
          if (launch) begin
            if (ldpend_q) begin
              // Word boundary: move prefetched data into the shifter, then prefetch the next word.
              ldpend_d = 1'b0;
              if (held_q || (pend_q && rd_valid)) begin
                tx_d = held_q ? hold_q : rd_data;
              end else begin
                tx_d      = '0;
                rd_miss_d = 1'b1;
              end
              held_d     = 1'b0;
              req_addr_d = req_addr_q + ADDR_STEP;
              rd_addr_d  = req_addr_q + ADDR_STEP;
              rd_req_d   = 1'b1;
              pend_d     = 1'b1;
            end else begin
              tx_d = tx_q << 1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      req_addr_q <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      held_q     <= 1'b0;
      pend_q     <= 1'b0;
      ldpend_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      wr_stb_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_miss_q  <= 1'b0;
      abort_q    <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      ldpend_q   <= ldpend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      wr_stb_q   <= wr_stb_d;
      rd_req_q   <= rd_req_d;
      rd_miss_q  <= rd_miss_d;
      abort_q    <= abort_d;
      if (ncs_lvl) arm_q <= 1'b1;
    end
  end

  assign so      = tx_q[DATA_WIDTH-1];
  assign so_oe   = arm_q & ~ncs_lvl;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_stb  = wr_stb_q;
  assign rd_addr = rd_addr_q;
  assign rd_req  = rd_req_q;
  assign busy    = (state_q != IDLE);
  assign rd_miss = rd_miss_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_soft_spi_slave_burst.sv
// Directed bench: one DUT per SPI mode, write/read scoreboards, abort and reset checks.
module tb_soft_spi_slave_burst;
  localparam int AW   = 7;
  localparam int DW   = 24;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] sck, ncs, so, so_oe, wr_stb, rd_req, rd_valid, busy, rd_miss, abort;
  logic si;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr [4];
  logic [AW-1:0] rd_addr [4];
  logic [DW-1:0] wr_data [4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    soft_spi_slave_burst #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPOL(m / 2), .CPHA(m % 2), .AUTO_INC(1)
    ) u_dut (
      .clk(clk), .rst(rst), .sck(sck[m]), .ncs(ncs[m]), .si(si),
      .so(so[m]), .so_oe(so_oe[m]), .wr_addr(wr_addr[m]), .wr_data(wr_data[m]),
      .wr_stb(wr_stb[m]), .rd_addr(rd_addr[m]), .rd_req(rd_req[m]), .rd_data(rd_data),
      .rd_valid(rd_valid[m]), .busy(busy[m]), .rd_miss(rd_miss[m]), .abort(abort[m])
    );
  end

  int tests = 0;
  int fails = 0;
  int cur = 0;
  int rd_lat = 2;
  int n_abort = 0;
  int n_miss = 0;
  logic [1+AW+DW:0] exp_wr [$];
  logic [1+AW+DW:0] obs_wr [$];
  logic [AW-1:0] req_log [$];

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {8'hA5, 1'b0, a, 1'b1, ~a};
  endfunction

  function automatic logic [44:0] outs(input int k);
    return {so[k], so_oe[k], wr_addr[k], wr_data[k], wr_stb[k], rd_addr[k],
            rd_req[k], busy[k], rd_miss[k], abort[k]};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    while (exp_wr.size() > 0 && obs_wr.size() > 0)
      chk({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
    exp_wr.delete();
    obs_wr.delete();
  endtask

  // Master: drives nbits of mosi MSB first, captures so just before each sample edge.
  task automatic frame(input int m, input int nbits, input logic [127:0] mosi,
                       input bit raise, output logic [127:0] miso);
    miso = '0;
    ncs[m] = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (m % 2 == 0) begin
        si = mosi[nbits-1-i];
        wait_clk(HALF);
        miso = {miso[126:0], so[m]};
        sck[m] = ~sck[m];
        wait_clk(HALF);
        sck[m] = ~sck[m];
      end else begin
        sck[m] = ~sck[m];
        si = mosi[nbits-1-i];
        wait_clk(HALF);
        miso = {miso[126:0], so[m]};
        sck[m] = ~sck[m];
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
    if (raise) begin
      ncs[m] = 1'b1;
      wait_clk(2 * HALF);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (wr_stb[k] === 1'b1) obs_wr.push_back({2'(k), wr_addr[k], wr_data[k]});
        if (abort[k] === 1'b1) n_abort++;
        if (rd_miss[k] === 1'b1) n_miss++;
      end
    end
  end

  initial begin : responder
    logic [AW-1:0] a;
    rd_valid = '0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rd_req[cur] === 1'b1) begin
        a = rd_addr[cur];
        req_log.push_back(a);
        if (rd_lat >= 0) begin
          repeat (rd_lat) @(negedge clk);
          rd_data = data_of(a);
          rd_valid[cur] = 1'b1;
          @(negedge clk);
          rd_valid = '0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [127:0] miso;
    int a0, m0, base;
    sck = 4'b1100;
    ncs = 4'hF;
    si  = 1'b0;
    rst = 1'b0;
    wait_clk(3);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_outs_m%0d", k), outs(k), '0);
    rst = 1'b1;
    wait_clk(2 * HALF);

    // Mode 0 single-word write.
    cur = 0;
    a0 = n_abort;
    exp_wr.push_back({2'd0, 7'h05, 24'h123456});
    frame(0, 32, {1'b0, 7'h05, 24'h123456}, 1'b1, miso);
    drain("m0_write");
    chk("m0_write_abort", n_abort - a0, 0);

    // Deselect during header: busy/so_oe while selected, abort on release.
    a0 = n_abort;
    ncs[0] = 1'b0;
    wait_clk(HALF);
    chk("hdr_busy", busy[0], 1'b1);
    chk("hdr_so_oe", so_oe[0], 1'b1);
    ncs[0] = 1'b1;
    wait_clk(HALF);
    chk("hdr_abort", n_abort - a0, 1);
    chk("hdr_idle_busy", busy[0], 1'b0);

    // Mode 3 burst write wrapping from 0x7F.
    cur = 3;
    exp_wr.push_back({2'd3, 7'h7F, 24'hA1B2C3});
    exp_wr.push_back({2'd3, 7'h00, 24'hD4E5F6});
    exp_wr.push_back({2'd3, 7'h01, 24'h0F1E2D});
    frame(3, 80, {1'b0, 7'h7F, 24'hA1B2C3, 24'hD4E5F6, 24'h0F1E2D}, 1'b1, miso);
    drain("m3_burst");

    // Mode 1 two-word burst read from 0x10.
    cur = 1;
    rd_lat = 2;
    m0 = n_miss;
    base = req_log.size();
    frame(1, 56, {1'b1, 7'h10, 48'h0}, 1'b1, miso);
    chk("m1_read_miso", miso[55:0], {8'h00, data_of(7'h10), data_of(7'h11)});
    chk("m1_read_nreq", req_log.size() - base, 3);
    chk("m1_read_req0", req_log[base], 7'h10);
    chk("m1_read_req1", req_log[base+1], 7'h11);
    chk("m1_read_miss", n_miss - m0, 0);
    drain("m1_read");

    // Mode 1 read with data withheld.
    rd_lat = -1;
    m0 = n_miss;
    base = req_log.size();
    frame(1, 32, {1'b1, 7'h20, 24'h0}, 1'b1, miso);
    chk("miss_count", n_miss - m0, 1);
    chk("miss_miso", miso[23:0], 24'h0);
    chk("miss_req0", req_log[base], 7'h20);
    rd_lat = 2;

    // Mode 2 abort after 10 data bits, then a clean frame.
    cur = 2;
    a0 = n_abort;
    frame(2, 18, {1'b0, 7'h33, 10'h2AB}, 1'b1, miso);
    chk("m2_abort", n_abort - a0, 1);
    chk("m2_abort_busy", busy[2], 1'b0);
    drain("m2_abort");
    a0 = n_abort;
    exp_wr.push_back({2'd2, 7'h33, 24'hABCDEF});
    frame(2, 32, {1'b0, 7'h33, 24'hABCDEF}, 1'b1, miso);
    drain("m2_after");
    chk("m2_after_abort", n_abort - a0, 0);

    // Reset during a mode 0 burst: first word lands, the rest is ignored.
    cur = 0;
    exp_wr.push_back({2'd0, 7'h40, 24'h111111});
    frame(0, 42, {1'b0, 7'h40, 24'h111111, 10'h155}, 1'b0, miso);
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", outs(0), '0);
    wait_clk(2);
    rst = 1'b1;
    wait_clk(4);
    a0 = n_abort;
    frame(0, 14, 128'h3FFF, 1'b1, miso);
    drain("rst_mid");
    chk("rst_mid_abort", n_abort - a0, 0);
    exp_wr.push_back({2'd0, 7'h41, 24'h5A5A5A});
    frame(0, 32, {1'b0, 7'h41, 24'h5A5A5A}, 1'b1, miso);
    drain("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
